// File: rtl/switch_egress_rx.sv
// switch_egress_rx: captures one switch output port, checks routing, queues good packets and keeps stats
module switch_egress_rx #(
    parameter int PORT_ID = 0,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_out,
    input  logic [3:0]           source_out,
    input  logic [3:0]           target_out,
    input  logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [1:0]           rd_source,
    output logic [DATA_W-1:0]    rd_data,
    output logic [4*CNT_W-1:0]   rx_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     ovf_count,
    input  logic                 clr_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic                    cap_v_q;
    logic [3:0]              cap_src_q, cap_tgt_q;
    logic [DATA_W-1:0]       cap_data_q;
    logic [PW-1:0]           wp_q, rp_q;
    logic [DATA_W+1:0]       mem_q [DEPTH];
    logic [3:0][CNT_W-1:0]   rx_q;
    logic [CNT_W-1:0]        err_q, ovf_q;
    logic [1:0]              src_enc;
    logic                    ok, full, empty, push, pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + CNT_W'(1) : c;
    endfunction

    assign src_enc = {cap_src_q[3] | cap_src_q[2], cap_src_q[3] | cap_src_q[1]};
    assign ok      = cap_tgt_q[PORT_ID] && $countones(cap_src_q) == 1;
    assign full    = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
    assign empty   = wp_q == rp_q;
    assign push    = cap_v_q && ok && !full;
    assign pop     = !empty && rd_ready;

    assign rd_valid              = !empty;
    assign {rd_source, rd_data}  = mem_q[rp_q[AW-1:0]];
    assign rx_count              = rx_q;
    assign err_count             = err_q;
    assign ovf_count             = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_v_q <= 1'b0;
        end else begin
            cap_v_q <= valid_out;
            if (valid_out) {cap_src_q, cap_tgt_q, cap_data_q} <= {source_out, target_out, data_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_q + PW'(push);
            rp_q <= rp_q + PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[AW-1:0]] <= {src_enc, cap_data_q};
    end

    // full is judged on start-of-cycle occupancy, so a same-cycle pop never rescues a push
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            rx_q  <= '0;
            err_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int s = 0; s < 4; s++) rx_q[s] <= sat_inc(rx_q[s], push && src_enc == 2'(s));
            err_q <= sat_inc(err_q, cap_v_q && !ok);
            ovf_q <= sat_inc(ovf_q, cap_v_q && ok && full);
        end
    end
endmodule

// File: tb/tb_switch_egress_rx.sv
// tb_switch_egress_rx: directed vectors for switch_egress_rx (PORT_ID=2, CNT_W=4)
module tb_switch_egress_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_out = 1'b0;
    logic [3:0]  source_out = '0;
    logic [3:0]  target_out = '0;
    logic [7:0]  data_out = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [1:0]  rd_source;
    logic [7:0]  rd_data;
    logic [15:0] rx_count;
    logic [3:0]  err_count;
    logic [3:0]  ovf_count;
    logic        clr_stats = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    switch_egress_rx #(.PORT_ID(2), .DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .valid_out(valid_out), .source_out(source_out),
        .target_out(target_out), .data_out(data_out), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_source(rd_source), .rd_data(rd_data),
        .rx_count(rx_count), .err_count(err_count), .ovf_count(ovf_count),
        .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic pkt(input logic [3:0] src, input logic [3:0] tgt, input logic [7:0] d);
        valid_out = 1'b1;
        source_out = src;
        target_out = tgt;
        data_out = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx"}, {16'h0, rx_count}, 32'h0);
        chk({tag, "_err"}, {28'h0, err_count}, 32'h0);
        chk({tag, "_ovf"}, {28'h0, ovf_count}, 32'h0);
    endtask

    initial begin
        int n;
        repeat (5) tick;
        chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk_all_zero("reset");
        rst = 1'b0;

        pkt(4'b0001, 4'b0100, 8'hA5);
        tick;
        valid_out = 1'b0;
        chk("single_not_yet", {31'h0, rd_valid}, 32'h0);
        tick;
        chk("single_valid", {31'h0, rd_valid}, 32'h1);
        chk("single_src", {30'h0, rd_source}, 32'h0);
        chk("single_data", {24'h0, rd_data}, 32'hA5);
        chk("single_rx0", {28'h0, rx_count[3:0]}, 32'h1);
        chk("single_err", {28'h0, err_count}, 32'h0);
        chk("single_ovf", {28'h0, ovf_count}, 32'h0);
        rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
        chk("single_popped", {31'h0, rd_valid}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            pkt(4'b1000, 4'b0100, 8'(i));
            tick;
        end
        valid_out = 1'b0;
        tick;
        chk("ovf_rx3", {28'h0, rx_count[15:12]}, 32'h8);
        chk("ovf_cnt", {28'h0, ovf_count}, 32'h2);
        chk("ovf_valid", {31'h0, rd_valid}, 32'h1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'h0, rd_valid}, 32'h1);
            chk("drain_src", {30'h0, rd_source}, 32'h3);
            chk("drain_data", {24'h0, rd_data}, 32'(i));
            tick;
        end
        chk("drain_empty", {31'h0, rd_valid}, 32'h0);
        rd_ready = 1'b0;

        pkt(4'b0001, 4'b0001, 8'h01);
        tick;
        pkt(4'b0011, 4'b0100, 8'h02);
        tick;
        pkt(4'b0000, 4'b0100, 8'h03);
        tick;
        valid_out = 1'b0;
        tick;
        chk("err_cnt", {28'h0, err_count}, 32'h3);
        chk("err_empty", {31'h0, rd_valid}, 32'h0);
        chk("err_rx", {16'h0, rx_count}, 32'h8001);

        for (int i = 0; i < 8; i++) begin
            pkt(4'b0010, 4'b0100, 8'h10 + 8'(i));
            tick;
        end
        pkt(4'b0010, 4'b0100, 8'hEE);
        tick;
        valid_out = 1'b0;
        rd_ready = 1'b1;
        chk("full_rx1", {28'h0, rx_count[7:4]}, 32'h8);
        chk("full_head", {24'h0, rd_data}, 32'h10);
        tick;
        rd_ready = 1'b0;
        chk("full_ovf", {28'h0, ovf_count}, 32'h3);
        chk("full_rx1_same", {28'h0, rx_count[7:4]}, 32'h8);
        chk("full_new_head", {24'h0, rd_data}, 32'h11);
        rd_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid) begin
                chk("full_drain_data", {24'h0, rd_data}, 32'h11 + 32'(n));
                n++;
            end
            tick;
        end
        chk("full_occupancy", 32'(n), 32'h7);

        clr_stats = 1'b1;
        tick;
        clr_stats = 1'b0;
        chk_all_zero("clr");
        for (int i = 0; i < 20; i++) begin
            pkt(4'b0010, 4'b0100, 8'(i));
            tick;
        end
        valid_out = 1'b0;
        tick;
        chk("sat_rx1", {28'h0, rx_count[7:4]}, 32'hF);
        chk("sat_ovf", {28'h0, ovf_count}, 32'h0);
        pkt(4'b0001, 4'b0100, 8'h55);
        tick;
        pkt(4'b0001, 4'b0001, 8'h66);
        clr_stats = 1'b1;
        tick;
        valid_out = 1'b0;
        clr_stats = 1'b0;
        chk_all_zero("clr_wins");
        tick;
        chk("clr_once_err", {28'h0, err_count}, 32'h1);
        tick;
        rd_ready = 1'b0;
        chk("clr_fifo_empty", {31'h0, rd_valid}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            pkt(4'b0100, 4'b0100, 8'h40 + 8'(i));
            tick;
        end
        chk("mid_rx2", {28'h0, rx_count[11:8]}, 32'h5);
        chk("mid_valid", {31'h0, rd_valid}, 32'h1);
        rst = 1'b1;
        pkt(4'b0100, 4'b0100, 8'h99);
        tick;
        rst = 1'b0;
        valid_out = 1'b0;
        chk("mid_rst_valid", {31'h0, rd_valid}, 32'h0);
        chk_all_zero("mid_rst");
        tick;
        chk("mid_no_push", {31'h0, rd_valid}, 32'h0);
        chk("mid_no_count", {16'h0, rx_count}, 32'h0);
        pkt(4'b0001, 4'b0100, 8'h3C);
        tick;
        valid_out = 1'b0;
        tick;
        chk("post_valid", {31'h0, rd_valid}, 32'h1);
        chk("post_data", {24'h0, rd_data}, 32'h3C);
        chk("post_rx0", {16'h0, rx_count}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
